// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, the responder FSM encoding and the store byte-enable helper.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // Byte lanes touched by a store. Halfwords pick the lane pair with
    // addr[1]; words always write all four lanes. Unknown codes write nothing.
    function automatic logic [3:0] be_from_funct3(input logic [2:0] funct3,
                                                  input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            F3_B:    be = 4'b0001 << addr_lo;
            F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core <-> data-memory bus. Two independent valid/ready channels:
// a transfer happens on a rising edge where valid && ready are both high;
// the sender holds valid and its payload stable until that edge, and
// the receiver may raise or drop ready freely.
interface data_mem_responder_if;
    import riscv_mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 data RAM: byte-enable write, registered (read-first)
// read. Contents are only changed by stores.
module dmem_array #(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           en_i,
    input  logic [3:0]                     we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // One access per enable: write the enabled lanes and capture the old word.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory bus. Accepts one load/store,
// waits LATENCY cycles, then holds the response until the core takes it.
// Build option: define MISALIGN_TRAP_EN to reject misaligned halfword/word
// accesses with rsp_err; otherwise the offending low address bits are ignored.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus,
    output mem_state_e            dbg_state_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q, err_d;

    logic        accept;
    logic        commit;
    logic        sel_we;
    logic [2:0]  sel_f3;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] lane_wdata;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic        legal_f3;
    logic        misalign;
    logic        unused_addr_bits;

    // Request side only open in IDLE and never while reset is asserted.
    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    // FSM state and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; commit marks the edge that enters RESP (memory access edge).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset wins: a store still waiting in BUSY never reaches the array.
        if (rst) begin
            commit = 1'b0;
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // With LATENCY=0 the commit edge is the accept edge, so take the live request.
    always_comb begin
        sel_we    = we_q;
        sel_f3    = f3_q;
        sel_addr  = addr_q;
        sel_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            sel_we    = bus.req_we;
            sel_f3    = bus.req_funct3;
            sel_addr  = bus.req_addr;
            sel_wdata = bus.req_wdata;
        end
    end

    // Legality and alignment of the committing access.
    always_comb begin
        legal_f3 = 1'b0;
        misalign = 1'b0;
        if (sel_we) begin
            legal_f3 = (sel_f3 == F3_B) || (sel_f3 == F3_H) || (sel_f3 == F3_W);
        end else begin
            legal_f3 = (sel_f3 == F3_B) || (sel_f3 == F3_H) || (sel_f3 == F3_W) ||
                       (sel_f3 == F3_BU) || (sel_f3 == F3_HU);
        end
`ifdef MISALIGN_TRAP_EN
        misalign = ((sel_f3[1:0] == 2'b01) && sel_addr[0]) ||
                   ((sel_f3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00));
`endif
        err_d = !legal_f3 || misalign;
    end

    // Error flag is decided once, on the commit edge, and held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (commit) begin
            err_q <= err_d;
        end
    end

    // Replicate store data across lanes so the byte enables pick the right bytes.
    always_comb begin
        case (sel_f3[1:0])
            2'b00:   lane_wdata = {4{sel_wdata[7:0]}};
            2'b01:   lane_wdata = {2{sel_wdata[15:0]}};
            default: lane_wdata = sel_wdata;
        endcase
        ram_we = (commit && sel_we && !err_d) ? be_from_funct3(sel_f3, sel_addr[1:0]) : 4'b0000;
    end

    assign unused_addr_bits = ^sel_addr[31:AW+2];

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .en_i    (commit),
        .we_i    (ram_we),
        .addr_i  (sel_addr[AW+1:2]),
        .wdata_i (lane_wdata),
        .rdata_o (ram_rdata)
    );

    // Lane select and sign/zero extension of the read word.
    always_comb begin
        byte_sel = ram_rdata[8*addr_q[1:0] +: 8];
        half_sel = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (f3_q)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            F3_W:    load_data = ram_rdata;
            default: load_data = 32'd0;
        endcase
    end

    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_err   = (state_q == ST_RESP) && err_q;
    assign bus.rsp_rdata = ((state_q == ST_RESP) && !err_q && !we_q) ? load_data : 32'd0;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=2, DEPTH_WORDS=1024).
// Expected values are hand-computed; outputs sampled 1ns after the rising edge.
module tb_data_mem_responder;
    import riscv_mem_pkg::*;

    logic       clk;
    logic       rst;
    mem_state_e dbg_state;
    int         n_checks;
    int         n_fail;
    int         lat;
    logic [31:0] rdata;
    logic       err;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (2),
        .INIT_FILE   ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request with rsp_ready high. lat = edges from accept to the edge on
    // which the core first samples rsp_valid high.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int l, output logic [31:0] rd,
                          output logic er);
        int k;
        check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        k = 1;
        while (!bus.rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        l  = k;
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        @(posedge clk); #1;
        check("rsp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        int k;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        rst = 1'b0;
        @(posedge clk); #1;

        // SW then LW, latency 3
        do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, lat, rdata, err);
        check("sw_lat", lat, 32'd3);
        check("sw_rdata", rdata, 32'd0);
        check("sw_err", {31'd0, err}, 32'd0);
        do_req(1'b0, F3_W, 32'h10, 32'd0, lat, rdata, err);
        check("lw_lat", lat, 32'd3);
        check("lw_rdata", rdata, 32'hDEADBEEF);

        // SB lane merge and byte loads
        do_req(1'b1, F3_B, 32'h11, 32'h12345680, lat, rdata, err);
        do_req(1'b0, F3_W, 32'h10, 32'd0, lat, rdata, err);
        check("sb_lw", rdata, 32'hDEAD80EF);
        do_req(1'b0, F3_B, 32'h11, 32'd0, lat, rdata, err);
        check("lb", rdata, 32'hFFFFFF80);
        do_req(1'b0, F3_BU, 32'h11, 32'd0, lat, rdata, err);
        check("lbu", rdata, 32'h00000080);

        // SH and halfword loads; word becomes 0x800180EF
        do_req(1'b1, F3_H, 32'h12, 32'hAAAA8001, lat, rdata, err);
        do_req(1'b0, F3_H, 32'h12, 32'd0, lat, rdata, err);
        check("lh", rdata, 32'hFFFF8001);
        do_req(1'b0, F3_HU, 32'h12, 32'd0, lat, rdata, err);
        check("lhu", rdata, 32'h00008001);
        do_req(1'b0, F3_H, 32'h10, 32'd0, lat, rdata, err);
        check("lh_low", rdata, 32'hFFFF80EF);
        do_req(1'b0, F3_B, 32'h13, 32'd0, lat, rdata, err);
        check("lb_b3", rdata, 32'hFFFFFF80);

        // Back-pressure: rsp_ready low for 5 cycles
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h10;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("bp_valid_rise", {31'd0, bus.rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_rdata_hold", bus.rsp_rdata, 32'h800180EF);
            check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_done", {31'd0, bus.rsp_valid}, 32'd0);
        check("bp_req_ready_after", {31'd0, bus.req_ready}, 32'd1);

        // Misaligned word load
        do_req(1'b0, F3_W, 32'h13, 32'd0, lat, rdata, err);
`ifdef MISALIGN_TRAP_EN
        check("lw_mis_err", {31'd0, err}, 32'd1);
        check("lw_mis_rdata", rdata, 32'd0);
`else
        check("lw_mis_err", {31'd0, err}, 32'd0);
        check("lw_mis_rdata", rdata, 32'h800180EF);
`endif

        // Store dropped by reset during BUSY
        do_req(1'b1, F3_W, 32'h20, 32'hCAFEF00D, lat, rdata, err);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rstb_busy", {30'd0, dbg_state}, {30'd0, ST_BUSY});
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstb_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("rstb_req_ready", {31'd0, bus.req_ready}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rstb_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        do_req(1'b0, F3_W, 32'h20, 32'd0, lat, rdata, err);
        check("rstb_lw", rdata, 32'hCAFEF00D);

        // Illegal funct3: load 011 and store 011 (no write)
        do_req(1'b0, 3'b011, 32'h20, 32'd0, lat, rdata, err);
        check("ill_ld_err", {31'd0, err}, 32'd1);
        check("ill_ld_rdata", rdata, 32'd0);
        do_req(1'b1, 3'b011, 32'h20, 32'h55555555, lat, rdata, err);
        check("ill_st_err", {31'd0, err}, 32'd1);
        do_req(1'b0, F3_W, 32'h20, 32'd0, lat, rdata, err);
        check("ill_st_nowrite", rdata, 32'hCAFEF00D);
        check("ok_err_clear", {31'd0, err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
